// File: rtl/seq_gen.sv
// seq_gen: loads a SEQ_W-bit word with PAT embedded at a chosen LSB position and streams
// it out MSB first over a valid/ready serial handshake.
// Optional feature: define SEQ_GEN_LFSR_FILL_EN to take filler bits from a 16-bit
// Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) instead of zeros.
module seq_gen #(
  parameter int unsigned      SEQ_W = 32,
  parameter int unsigned      PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT   = 4'b1011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       posi,
  input  logic             seq_ready,
  output logic             seq_bit,
  output logic             seq_valid,
  output logic [SEQ_W-1:0] seq_word,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CntW    = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam int unsigned MaxPosi = SEQ_W - PAT_W;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [5:0]       posi_q;
  logic             posi_ok;
  logic [SEQ_W-1:0] pat_word;
  logic [SEQ_W-1:0] pat_mask;
  logic [SEQ_W-1:0] fill_word;
  logic [SEQ_W-1:0] load_word;

  // Unsigned range check on the 6-bit position only.
  assign posi_ok = ({26'd0, posi} <= MaxPosi);

`ifdef SEQ_GEN_LFSR_FILL_EN
  localparam int unsigned FillReps = (SEQ_W + 15) / 16;

  logic [15:0]            lfsr_q;
  logic [FillReps*16-1:0] fill_rep;

  // Replicating the LFSR gives word bit i = lfsr[i mod 16].
  assign fill_rep  = {FillReps{lfsr_q}};
  assign fill_word = fill_rep[SEQ_W-1:0];

  // LFSR: right-shifting Fibonacci form, advances once per LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (state_q == StLoad) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end
`else
  assign fill_word = '0;
`endif

  // Word assembled in LOAD: pattern at posi_q, filler everywhere else.
  always_comb begin
    pat_word  = {{(SEQ_W-PAT_W){1'b0}}, PAT} << posi_q;
    pat_mask  = {{(SEQ_W-PAT_W){1'b0}}, {PAT_W{1'b1}}} << posi_q;
    load_word = pat_word | (fill_word & ~pat_mask);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      posi_q    <= '0;
      seq_word  <= '0;
      seq_bit   <= 1'b0;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (posi_ok) begin
              posi_q  <= posi;
              busy    <= 1'b1;
              state_q <= StLoad;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StLoad: begin
          seq_word  <= load_word;
          cnt_q     <= CntW'(SEQ_W - 1);
          seq_bit   <= load_word[SEQ_W-1];
          seq_valid <= 1'b1;
          state_q   <= StShift;
        end
        StShift: begin
          // seq_valid is always 1 here, so ready alone decides the transfer.
          if (seq_ready) begin
            if (cnt_q == '0) begin
              seq_valid <= 1'b0;
              seq_bit   <= 1'b0;
              done      <= 1'b1;
              state_q   <= StDone;
            end else begin
              cnt_q   <= cnt_q - CntW'(1);
              seq_bit <= seq_word[cnt_q - CntW'(1)];
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a word/queue-level reference model checked on every cycle, plus
// directed cases with hand-computed expectations and a randomized phase.
module tb_seq_gen;

  localparam int SEQ_W   = 32;
  localparam int PAT_W   = 4;
  localparam int PAT_INT = 11;  // 4'b1011

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  posi;
  logic        seq_ready;
  logic        seq_bit;
  logic        seq_valid;
  logic [31:0] seq_word;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  seq_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .posi      (posi),
    .seq_ready (seq_ready),
    .seq_bit   (seq_bit),
    .seq_valid (seq_valid),
    .seq_word  (seq_word),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after each rising edge; outputs are sampled on falling edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected word from the placement rules: pattern bits at [p+PAT_W-1:p], filler elsewhere.
  function automatic logic [31:0] exp_word(input int p, input int l);
    logic [31:0] w;
    int b;
    w = '0;
    for (int i = 0; i < SEQ_W; i++) begin
      if (i >= p && i < p + PAT_W) b = (PAT_INT >> (i - p)) & 1;
`ifdef SEQ_GEN_LFSR_FILL_EN
      else b = (l >> (i % 16)) & 1;
`else
      else b = 0;
`endif
      w = w | (32'(b) << i);
    end
    return w;
  endfunction

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return ((l >> 1) | (fb << 15)) & 16'hFFFF;
  endfunction

  // Reference model: phase follows the named states, bits pending are kept in a queue.
  int   m_phase;  // 0 idle, 1 load, 2 shift, 3 done
  int   m_posi;
  int   m_lfsr;
  logic [31:0] m_word;
  logic m_err;
  logic m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_posi  = 0;
      m_lfsr  = 16'hACE1;
      m_word  = '0;
      m_err   = 1'b0;
      m_q.delete();
    end else begin
      m_err = 1'b0;
      case (m_phase)
        0: if (start) begin
          if (int'(posi) <= SEQ_W - PAT_W) begin
            m_posi  = int'(posi);
            m_phase = 1;
          end else begin
            m_err = 1'b1;
          end
        end
        1: begin
          m_word = exp_word(m_posi, m_lfsr);
          m_lfsr = lfsr_step(m_lfsr);
          m_q.delete();
          for (int i = SEQ_W - 1; i >= 0; i--) m_q.push_back(((m_word >> i) & 32'd1) != 0);
          m_phase = 2;
        end
        2: if (seq_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_busy", 32'(busy), 32'(m_phase != 0));
    chk("cyc_valid", 32'(seq_valid), 32'(m_phase == 2));
    chk("cyc_done", 32'(done), 32'(m_phase == 3));
    chk("cyc_err", 32'(err), 32'(m_err));
    chk("cyc_word", seq_word, m_word);
    if (m_phase == 2 && m_q.size() > 0) chk("cyc_bit", 32'(seq_bit), 32'(m_q[0]));
  end

  // Issues one start and follows it to done; optionally toggles ready and injects a
  // second start (posi=10) in a given cycle.
  task automatic run_seq(input logic [5:0] p, input bit toggle_rdy, input int second_at,
                         output logic [31:0] bits, output int done_cyc, output int nbits);
    bits      = '0;
    nbits     = 0;
    done_cyc  = 0;
    start     = 1'b1;
    posi      = p;
    seq_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (seq_valid && seq_ready) begin
        bits = {bits[30:0], seq_bit};
        nbits++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      if (toggle_rdy) seq_ready = ~seq_ready;
      start = (cyc == second_at);
      posi  = (cyc == second_at) ? 6'd10 : p;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc != 0), 32'd1);
  endtask

  logic [31:0] bits;
  logic [31:0] w_first;
  int          dcyc;
  int          nb;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    posi      = '0;
    seq_ready = 1'b0;
    @(negedge clk);
    chk("rst_word", seq_word, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(seq_valid), 32'd0);
    chk("rst_bit", 32'(seq_bit), 32'd0);
    tick();
    rst_n = 1'b1;

    // Basic send at posi=5, started on the first edge after reset release.
    run_seq(6'd5, 1'b0, -1, bits, dcyc, nb);
    w_first = seq_word;
    chk("basic_done_cycle", 32'(dcyc), 32'd34);
    chk("basic_nbits", 32'(nb), 32'd32);
    chk("basic_serial", bits, seq_word);
    chk("basic_pat", 32'(seq_word[8:5]), 32'hB);
`ifdef SEQ_GEN_LFSR_FILL_EN
    // Seed ACE1 with bits [8:5] replaced by 1011.
    chk("basic_word", seq_word, 32'hACE1AD61);
`else
    // 1011 at [8:5].
    chk("basic_word", seq_word, 32'h00000160);
`endif

    // Highest legal position: pattern goes out first.
    tick();
    run_seq(6'd28, 1'b0, -1, bits, dcyc, nb);
    chk("hi_first4", 32'(bits[31:28]), 32'hB);
    chk("hi_done_cycle", 32'(dcyc), 32'd34);
`ifndef SEQ_GEN_LFSR_FILL_EN
    chk("hi_word", seq_word, 32'hB0000000);
`endif

    // Out-of-range position: err pulse, no busy, word kept.
    tick();
    start = 1'b1;
    posi  = 6'd29;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_busy", 32'(busy), 32'd0);
`ifndef SEQ_GEN_LFSR_FILL_EN
    chk("oor_word", seq_word, 32'hB0000000);
`endif
    tick();
    @(negedge clk);
    chk("oor_err_one_cycle", 32'(err), 32'd0);

    // Backpressure with ready toggling.
    tick();
    run_seq(6'd0, 1'b1, -1, bits, dcyc, nb);
    chk("bp_nbits", 32'(nb), 32'd32);
    chk("bp_serial", bits, seq_word);
    chk("bp_slow", 32'(dcyc >= 64), 32'd1);
`ifndef SEQ_GEN_LFSR_FILL_EN
    chk("bp_word", seq_word, 32'h0000000B);
`endif

    // Start during DONE is ignored.
    start = 1'b1;
    posi  = 6'd5;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("done_start_ignored", 32'(busy), 32'd0);

    // Second start mid-SHIFT is ignored.
    tick();
    run_seq(6'd5, 1'b0, 10, bits, dcyc, nb);
    chk("busy_start_cycle", 32'(dcyc), 32'd34);
    chk("busy_start_serial", bits, seq_word);
    chk("busy_start_pat", 32'(seq_word[8:5]), 32'hB);
`ifdef SEQ_GEN_LFSR_FILL_EN
    chk("lfsr_fill_differs", 32'(seq_word != w_first), 32'd1);
`else
    chk("busy_start_word", seq_word, 32'h00000160);
`endif

    // Reset after 12 bits.
    tick();
    tick();
    start     = 1'b1;
    posi      = 6'd3;
    seq_ready = 1'b1;
    tick();
    start = 1'b0;
    nb    = 0;
    for (int c = 0; c < 100 && nb < 12; c++) begin
      @(negedge clk);
      if (seq_valid && seq_ready) nb++;
      if (nb < 12) tick();
    end
    chk("rst_mid_reached", 32'(nb), 32'd12);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(seq_valid), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_word", seq_word, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    run_seq(6'd28, 1'b0, -1, bits, dcyc, nb);
    chk("post_rst_cycle", 32'(dcyc), 32'd34);
    chk("post_rst_first4", 32'(bits[31:28]), 32'hB);

    // Randomized phase; every cycle is checked by the model.
    for (int i = 0; i < 1500; i++) begin
      tick();
      start     = ($urandom_range(0, 7) == 0);
      posi      = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 28))
                                              : 6'($urandom_range(0, 63));
      seq_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    start     = 1'b0;
    seq_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
